// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one single-ported memory between fetch (read-only) and load/store ports.
// One access issued per cycle, response strobe one cycle after issue; requesters hold req until their rvalid.
module mem_arb #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_wmask,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_strb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {PORT_IF = 1'b0, PORT_LS = 1'b1} port_e;

  logic  rsp_vld;
  port_e rsp_port;
  logic  rsp_err;
  logic  rsp_wr;
  port_e last_gnt;

  logic        if_elig, ls_elig;
  logic        gnt_vld;
  port_e       gnt_port;
  logic [31:0] sel_addr;
  logic [29:0] word;
  logic        in_range;
  logic        is_store;

  always_comb begin
    // A port already being answered this cycle is still holding the request it was granted for.
    if_elig  = if_req && !(rsp_vld && rsp_port == PORT_IF);
    ls_elig  = ls_req && !(rsp_vld && rsp_port == PORT_LS);
    gnt_vld  = if_elig || ls_elig;
    if (if_elig && ls_elig)
      gnt_port = (last_gnt == PORT_IF) ? PORT_LS : PORT_IF;
    else
      gnt_port = ls_elig ? PORT_LS : PORT_IF;
    sel_addr = (gnt_port == PORT_LS) ? ls_addr : if_addr;
    word     = sel_addr[31:2];
    in_range = (word[29:AW] == '0) && ({1'b0, word[AW-1:0]} < (AW+1)'(DEPTH));
    is_store = (gnt_port == PORT_LS) && (ls_wmask != 4'b0);
  end

  always_comb begin
    mem_strb  = 1'b0;
    mem_addr  = 32'b0;
    mem_wdata = 32'b0;
    mem_wmask = 4'b0;
    if (rstn && gnt_vld) begin
      mem_addr = sel_addr;
      if (in_range) begin
        if (is_store) begin
          mem_wmask = ls_wmask;
          mem_wdata = ls_wdata;
        end else begin
          mem_strb = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_vld  <= 1'b0;
      rsp_port <= PORT_IF;
      rsp_err  <= 1'b0;
      rsp_wr   <= 1'b0;
      last_gnt <= PORT_IF;
    end else begin
      rsp_vld <= gnt_vld;
      if (gnt_vld) begin
        rsp_port <= gnt_port;
        rsp_wr   <= is_store;
        rsp_err  <= !in_range;
        last_gnt <= gnt_port;
      end
    end
  end

  always_comb begin
    if_rvalid = rsp_vld && (rsp_port == PORT_IF);
    ls_rvalid = rsp_vld && (rsp_port == PORT_LS);
    if_err    = if_rvalid && rsp_err;
    ls_err    = ls_rvalid && rsp_err;
    if_rdata  = (if_rvalid && !rsp_err && !rsp_wr) ? mem_rdata : 32'b0;
    ls_rdata  = (ls_rvalid && !rsp_err && !rsp_wr) ? mem_rdata : 32'b0;
  end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Two-port arbiter that shares the single-ported instruction/data memory (`BUS`-wide, word-addressed, 1-cycle registered read) between the core's instruction-fetch port (read-only) and load/store port (read/write).
- Performs round-robin arbitration on conflict and range-checks addresses against the memory depth.
- Issues one memory access per cycle.
- Returns a one-cycle response pulse to the requester whose access was issued on the previous cycle.

Parameters:
- DEPTH, 512, number of 32-bit words in the memory; word addresses at or above DEPTH are out of range.
- AW, 9, word-address width used for the range check; equals clog2(DEPTH).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held with if_addr stable until if_rvalid.
- if_addr  in  32  fetch byte address; bits [1:0] ignored.
- if_rvalid  out  1  one-cycle response strobe to the fetch port.
- if_rdata  out  32  fetch data, valid while if_rvalid is high, else 0.
- if_err  out  1  fetch address out of range; valid with if_rvalid.
- ls_req  in  1  load/store request; held with addr/wdata/wmask stable until ls_rvalid.
- ls_addr  in  32  load/store byte address; bits [1:0] ignored.
- ls_wdata  in  32  store data.
- ls_wmask  in  4  byte write enables; 0 means load.
- ls_rvalid  out  1  one-cycle response strobe to the load/store port.
- ls_rdata  out  32  load data; 0 for stores and errors.
- ls_err  out  1  load/store address out of range; valid with ls_rvalid.
- mem_strb  out  1  memory read strobe.
- mem_addr  out  32  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_wmask  out  4  memory byte write enables.
- mem_rdata  in  32  memory read data; valid the cycle after mem_strb.

Behaviour:
- Registered state:
  - rsp_vld: a response is due this cycle.
  - rsp_port: IF=0, LS=1.
  - rsp_err, rsp_wr.
  - last_gnt: last granted port.
- Reset (rstn low, asynchronous):
  - rsp_vld=0, rsp_err=0, rsp_wr=0, last_gnt=IF.
  - if_rvalid=ls_rvalid=0 and if_rdata=ls_rdata=0 immediately.
  - mem_strb=0, mem_wmask=0, mem_addr=0, mem_wdata=0 while rstn is low.
  - No memory access is issued during reset.
- Eligibility each cycle:
  - A port is eligible if its req is high and it is not being responded to this cycle (rsp_vld && rsp_port==port).
  - This prevents a double grant of a held request.
- Grant, combinational, same cycle:
  - One eligible port is granted.
  - If both are eligible, the port != last_gnt wins.
  - After reset, the first tie goes to LS.
- Issue in the grant cycle:
  - mem_addr is driven with the granted address.
  - If addr[31:2] < DEPTH:
    - Load/fetch: mem_strb=1, mem_wmask=0.
    - Store: mem_strb=0, mem_wmask=ls_wmask, mem_wdata=ls_wdata.
  - If out of range: mem_strb=0, mem_wmask=0, and rsp_err is set.
  - With no grant: mem_strb=0, mem_wmask=0, mem_addr=0, mem_wdata=0.
- Edge after a grant:
  - rsp_vld=1, rsp_port=granted port, rsp_wr=(grant LS && ls_wmask!=0), rsp_err=out-of-range, last_gnt=granted port.
  - With no grant: rsp_vld=0.
- Response cycle:
  - The port's rvalid is high for exactly one cycle.
  - rdata = mem_rdata if !rsp_err && !rsp_wr, else 0.
  - err = rsp_err.
  - The other port's outputs stay 0.
- Latency: 1 cycle request-to-response when uncontended.
- Throughput: 1 access per cycle. Issue for the other port overlaps the response cycle, so continuous dual requests alternate IF, LS, IF, LS.
- Requester rule: after rvalid, req may drop or a new request may be presented from the next cycle.
- Reset mid-operation: a pending response is discarded with no rvalid. A store already sampled by memory is not undone.

Test Plan:
- Single fetch: if_req=1, if_addr=0x10, mem[4]=0x00000013 -> mem_strb=1 and mem_addr=0x10 in cycle 0; cycle 1 if_rvalid=1, if_rdata=0x00000013, if_err=0; ls outputs 0.
- Store then load: ls_addr=0x20, ls_wdata=0xDEADBEEF, ls_wmask=0b0011 over old word 0 -> cycle 1 ls_rvalid=1, ls_rdata=0. A following load of 0x20 returns 0x0000BEEF.
- Contention: if_req and ls_req both held from reset, with new requests re-presented after each response -> grants LS, IF, LS, IF on consecutive cycles; each rvalid arrives 1 cycle after its grant; no cycle has both rvalids high.
- Out of range: ls_addr=0x800 (word 512), ls_wmask=0xF -> mem_wmask=0 and mem_strb=0; next cycle ls_rvalid=1, ls_err=1, ls_rdata=0; memory unchanged.
- Held request: if_req held high for 3 cycles with no new address -> exactly one issue in cycle 0; rvalid in cycle 1; re-issue in cycle 2, not cycle 1.
- Async reset: rstn pulled low mid-cycle between grant and response -> if_rvalid stays 0, mem_strb drops to 0 immediately; after release, the first contention grants LS.
